// File: rtl/kugelblitz_byte_patch_pkg.sv
// kugelblitz_byte_patch shared definitions.
// Stream geometry, counter width, control states, byte helper.
package kugelblitz_byte_patch_pkg;

  localparam int KG_AXIS_DATA_WIDTH = 512;
  localparam int KG_AXIS_KEEP_WIDTH = 64;
  localparam int KG_LANE_BITS       = 6;
  localparam int KG_OFFSET_WIDTH    = 16;
  localparam int KG_CNT_WIDTH       = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } ctl_state_t;

  function automatic logic [KG_AXIS_DATA_WIDTH-1:0] put_byte(
    input logic [KG_AXIS_DATA_WIDTH-1:0] d,
    input logic [KG_LANE_BITS-1:0]       lane,
    input logic [7:0]                    b
  );
    logic [KG_AXIS_DATA_WIDTH-1:0] r;
    r = d;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/kugelblitz_byte_patch_if.sv
// AXI-stream bundle used on both sides of the patch stage.
// master drives payload/valid, slave drives ready.
interface kugelblitz_byte_patch_if #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 1
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );

endinterface

// File: rtl/kugelblitz_axis_skid.sv
// Generic 2-entry AXI-stream register slice.
// Output register plus one skid entry; ready is registered.
module kugelblitz_axis_skid #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  kugelblitz_byte_patch_if.slave  s,
  kugelblitz_byte_patch_if.master m
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = DATA_WIDTH + KW + 1 + USER_WIDTH;

  logic [PW-1:0] r_out;
  logic [PW-1:0] r_skd;
  logic          r_out_vld;
  logic          r_skd_vld;
  logic          r_ready;

  logic [PW-1:0] w_in;
  logic          w_in_fire;
  logic          w_load;

  assign w_in      = {s.tdata, s.tkeep, s.tlast, s.tuser};
  assign w_in_fire = s.tvalid && r_ready;
  assign w_load    = !r_out_vld || m.tready;

  assign s.tready = r_ready;
  assign m.tvalid = r_out_vld;
  assign {m.tdata, m.tkeep, m.tlast, m.tuser} = r_out;

  // Output register refills from skid first, else from input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_skd     <= '0;
      r_out_vld <= 1'b0;
      r_skd_vld <= 1'b0;
      r_ready   <= 1'b0;
    end else if (w_load) begin
      if (r_skd_vld) begin
        r_out     <= r_skd;
        r_out_vld <= 1'b1;
        r_skd_vld <= 1'b0;
      end else begin
        r_out_vld <= w_in_fire;
        if (w_in_fire) r_out <= w_in;
      end
      r_ready <= 1'b1;
    end else if (w_in_fire) begin
      r_skd     <= w_in;
      r_skd_vld <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_ready <= !r_skd_vld;
    end
  end

endmodule

// File: rtl/kugelblitz_byte_patch.sv
// TX-path stage overwriting one byte at a programmed frame offset.
// Config latch, beat counter, patch mux, status counters.
module kugelblitz_byte_patch
  import kugelblitz_byte_patch_pkg::*;
#(
  parameter int DATA_WIDTH   = KG_AXIS_DATA_WIDTH,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1,
  parameter int OFFSET_WIDTH = KG_OFFSET_WIDTH,
  parameter int CNT_WIDTH    = KG_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  kugelblitz_byte_patch_if.slave  s_axis,
  kugelblitz_byte_patch_if.master m_axis,
  input  logic                    cfg_enable,
  input  logic [OFFSET_WIDTH-1:0] cfg_offset,
  input  logic [7:0]              cfg_data,
  output logic [CNT_WIDTH-1:0]    stat_frames,
  output logic [CNT_WIDTH-1:0]    stat_patched,
  output logic [CNT_WIDTH-1:0]    stat_short
);

  localparam int BW = OFFSET_WIDTH - KG_LANE_BITS;

  ctl_state_t            r_state;
  logic [BW-1:0]         r_beat;
  logic                  r_en;
  logic [OFFSET_WIDTH-1:0] r_off;
  logic [7:0]            r_dat;
  logic [CNT_WIDTH-1:0]  r_frames;
  logic [CNT_WIDTH-1:0]  r_patched;
  logic [CNT_WIDTH-1:0]  r_short;

  logic                    w_fire;
  logic                    w_first;
  logic                    w_en;
  logic [OFFSET_WIDTH-1:0] w_off;
  logic [7:0]              w_dat;
  logic [BW-1:0]           w_tgt;
  logic [KG_LANE_BITS-1:0] w_lane;
  logic                    w_lane_on;
  logic                    w_hit;
  logic                    w_short;
  logic                    w_out_last;
  logic [KEEP_WIDTH-1:0]   w_keep;

  kugelblitz_byte_patch_if #(
    .DATA_WIDTH(DATA_WIDTH),
    .USER_WIDTH(USER_WIDTH)
  ) w_pat ();

  // First beat of a frame sees live config, later beats the latched copy.
  assign w_first   = (r_state == ST_IDLE);
  assign w_en      = w_first ? cfg_enable : r_en;
  assign w_off     = w_first ? cfg_offset : r_off;
  assign w_dat     = w_first ? cfg_data   : r_dat;
  assign w_tgt     = w_off[OFFSET_WIDTH-1:KG_LANE_BITS];
  assign w_lane    = w_off[KG_LANE_BITS-1:0];
  assign w_keep    = s_axis.tkeep;
  assign w_lane_on = w_keep[w_lane];

  assign w_fire  = s_axis.tvalid && w_pat.tready;
  assign w_hit   = w_en && (r_beat == w_tgt) && w_lane_on;
  assign w_short = w_en && s_axis.tlast &&
                   ((r_beat < w_tgt) ||
                    ((r_beat == w_tgt) && !w_lane_on));

  assign w_pat.tdata  = w_hit ? put_byte(s_axis.tdata, w_lane, w_dat)
                              : s_axis.tdata;
  assign w_pat.tkeep  = s_axis.tkeep;
  assign w_pat.tvalid = s_axis.tvalid;
  assign w_pat.tlast  = s_axis.tlast;
  assign w_pat.tuser  = s_axis.tuser;
  assign s_axis.tready = w_pat.tready;

  kugelblitz_axis_skid #(
    .DATA_WIDTH(DATA_WIDTH),
    .USER_WIDTH(USER_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (w_pat),
    .m     (m_axis)
  );

  assign w_out_last = m_axis.tvalid && m_axis.tready && m_axis.tlast;

  // Frame FSM, config latch and saturating beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_en    <= 1'b0;
      r_off   <= '0;
      r_dat   <= '0;
    end else if (w_fire) begin
      if (r_state == ST_IDLE) begin
        r_en  <= cfg_enable;
        r_off <= cfg_offset;
        r_dat <= cfg_data;
      end
      if (s_axis.tlast) begin
        r_state <= ST_IDLE;
        r_beat  <= '0;
      end else begin
        r_state <= ST_FRAME;
        if (!(&r_beat)) r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Wrapping status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frames  <= '0;
      r_patched <= '0;
      r_short   <= '0;
    end else begin
      if (w_out_last)         r_frames  <= r_frames + 1'b1;
      if (w_fire && w_hit)    r_patched <= r_patched + 1'b1;
      if (w_fire && w_short)  r_short   <= r_short + 1'b1;
    end
  end

  assign stat_frames  = r_frames;
  assign stat_patched = r_patched;
  assign stat_short   = r_short;

endmodule
